// File: rtl/gvt_monitor.sv
// GVT monitor: scans per-core event timestamps plus the event-queue minimum
// once per round, advances a monotonic global virtual time, and flags completion.
module gvt_monitor #(
  parameter int NUM_CORE = 8,
  parameter int TIME_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CORE-1:0]        core_active,
  input  logic [NUM_CORE*TIME_W-1:0] core_time,
  input  logic [TIME_W-1:0]          queue_min_time,
  input  logic                       queue_empty,
  input  logic [TIME_W-1:0]          sim_end,
  input  logic                       stall_in,
  input  logic                       event_commit,
  output logic [TIME_W-1:0]          gvt,
  output logic                       gvt_upd,
  output logic                       rtn_vld,
  output logic [63:0]                total_cycles,
  output logic [63:0]                total_stalls,
  output logic [63:0]                total_events
);

  localparam int IDX_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORE - 1);

  typedef enum logic [1:0] {SCAN, UPDATE, DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [TIME_W-1:0] r_min;
  logic              r_min_vld;

  logic [TIME_W-1:0] times [NUM_CORE];
  logic [TIME_W-1:0] base_min, cur_time, cand;
  logic              base_vld, take;

  // The SCAN-entry load of the queue minimum is folded into the idx==0 cycle,
  // so a round is exactly NUM_CORE scan cycles plus one update cycle.
  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    for (int i = 0; i < NUM_CORE; i++) begin
      times[i] = core_time[i*TIME_W +: TIME_W];
    end
    base_min = r_min;
    base_vld = r_min_vld;
    if (idx == '0) begin
      base_min = queue_min_time;
      base_vld = !queue_empty;
    end
    cur_time = times[idx];
    take     = core_active[idx] && (!base_vld || (cur_time < base_min));
    cand     = sim_end;
    if (r_min_vld && (r_min < sim_end)) begin
      cand = r_min;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset
  // clears every flop, including the scan accumulator, so an aborted round leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SCAN;
      idx          <= '0;
      r_min        <= '0;
      r_min_vld    <= 1'b0;
      gvt          <= '0;
      gvt_upd      <= 1'b0;
      rtn_vld      <= 1'b0;
      total_cycles <= '0;
      total_stalls <= '0;
      total_events <= '0;
    end else begin
      gvt_upd <= 1'b0;
      rtn_vld <= 1'b0;

      if (state != DONE) begin
        total_cycles <= total_cycles + 64'd1;
        total_stalls <= total_stalls + {63'd0, stall_in};
        total_events <= total_events + {63'd0, event_commit};
      end

      case (state)
        SCAN: begin
          r_min     <= take ? cur_time : base_min;
          r_min_vld <= take | base_vld;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= UPDATE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        UPDATE: begin
          if (cand > gvt) begin
            gvt     <= cand;
            gvt_upd <= 1'b1;
          end
          // An empty system has nothing left to simulate: finish at sim_end.
          if ((cand >= sim_end) || !r_min_vld) begin
            state   <= DONE;
            rtn_vld <= 1'b1;
          end else begin
            state <= SCAN;
          end
        end
        DONE: ;
        default: state <= SCAN;
      endcase
    end
  end

endmodule
